operand_loader: RTL and testbench
=================================

OPERAND_LOADER -- requirements
Module: operand_loader

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, listed first: clk  input  1  rising-edge clock; rst_n  input  1  asynchronous active-low reset.
REQ-002 The block SHALL have dato_in  input  8  shared operand bus carrying A, then B.
REQ-003 The block SHALL have cargar  input  1  load strobe, level from pin; each rising edge loads one operand.
REQ-004 The block SHALL have cantidad_in  input  3  shift amount, sampled with the B load.
REQ-005 The block SHALL have tomar  input  1  consumer accept, honoured only while valido=1.
REQ-006 The block SHALL have cancelar  input  1  synchronous abort of a partial load.
REQ-007 The block SHALL have A, B  output  8 each  registered operands for the shifter stage.
REQ-008 The block SHALL have Cantidad  output  3  registered shift amount.
REQ-009 The block SHALL have valido  output  1  A/B/Cantidad form a complete pair.
REQ-010 The block SHALL have estado  output  2  current state code.
REQ-011 The block SHALL have pares  output  4  count of accepted pairs.

Function
REQ-012 The state machine SHALL have exactly three states, encoded on estado: ESPERA_A=00, ESPERA_B=01, LISTO=10; code 11 is unreachable and, if entered, SHALL go to ESPERA_A on the next clock.
REQ-013 Edge detection SHALL use a registered copy of the strobe (cargar_prev); an edge is strobe=1 with cargar_prev=0; one edge = exactly one load, however long cargar is held.
REQ-014 On an edge in ESPERA_A, A SHALL load from dato_in at that clock and the state SHALL go to ESPERA_B.
REQ-015 On an edge in ESPERA_B, B SHALL load from dato_in and Cantidad from cantidad_in at that clock, and the state SHALL go to LISTO.
REQ-016 valido SHALL be 1 exactly while in LISTO; it SHALL rise the cycle after the B-load clock edge (1-cycle latency).
REQ-017 In LISTO, edges SHALL be ignored (dropped, not queued); A, B and Cantidad SHALL hold.
REQ-018 tomar=1 in LISTO SHALL move to ESPERA_A and increment pares mod 16 (15 -> 0); valido falls the next cycle.
REQ-019 tomar outside LISTO SHALL have no effect.
REQ-020 A, B and Cantidad SHALL retain their last values after acceptance; they SHALL change only on their own load.
REQ-021 cancelar=1 SHALL force ESPERA_A from any state, with priority over edge and tomar.
REQ-022 cancelar SHALL NOT change A, B, Cantidad or pares.
REQ-023 When tomar and an edge occur in the same LISTO cycle, tomar SHALL win and the edge SHALL be dropped; the next load requires a fresh edge.
REQ-024 All outputs SHALL be driven directly from flops, with no combinational path from any input to any output.

Reset
REQ-025 rst_n=0 SHALL immediately clear A, B, Cantidad, valido and pares to 0, set estado=00 (ESPERA_A), and set cargar_prev (and any synchronizer flops) to 1.
REQ-026 Because cargar_prev resets to 1, a strobe held high through reset release SHALL NOT produce a load.
REQ-027 Reset asserted mid-load (in ESPERA_B) SHALL discard the partial operand.

Configuration
REQ-028 Macro OPERAND_LOADER_SYNC_EN: when defined, cargar SHALL pass through a 2-flop synchronizer before edge detection, delaying every load by 2 clocks.
REQ-029 With OPERAND_LOADER_SYNC_EN defined, dato_in and cantidad_in SHALL be held stable for at least 3 clocks after cargar rises.
REQ-030 Without OPERAND_LOADER_SYNC_EN, cargar SHALL feed edge detection directly and no synchronizer flops SHALL exist.

Verification
REQ-031 Basic load: reset, pulse cargar with dato_in=0x5A, then pulse with dato_in=0xC3 and cantidad_in=3 -> A=0x5A, B=0xC3, Cantidad=3, valido=1 one cycle after the second load, estado=10.
REQ-032 Held strobe: hold cargar high 10 cycles with dato_in=0x11 -> only A loads, estado=01, B unchanged.
REQ-033 Simultaneous events: in LISTO, assert tomar and a cargar edge with dato_in=0xFF in the same cycle -> estado=00, pares+1, A unchanged.
REQ-034 Abort: load A=0x22, then cancelar=1 -> estado=00, A=0x22 retained, valido=0, pares unchanged.
REQ-035 Counter wrap: complete and accept 16 pairs -> pares returns to 0.
REQ-036 Reset cases: reset with cargar held high, release -> no load; assert rst_n=0 in ESPERA_B -> all outputs 0 immediately; repeat REQ-031 with OPERAND_LOADER_SYNC_EN defined -> each load 2 cycles later.

Source files
------------

// File: rtl/operand_loader.sv
// Two-operand loader for the shifter stage: A then B (with shift amount) arrive on a shared bus.
// Optional macro OPERAND_LOADER_SYNC_EN inserts a 2-flop synchronizer on cargar before edge detection.
module operand_loader (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] dato_in,
    input  logic       cargar,
    input  logic [2:0] cantidad_in,
    input  logic       tomar,
    input  logic       cancelar,
    output logic [7:0] A,
    output logic [7:0] B,
    output logic [2:0] Cantidad,
    output logic       valido,
    output logic [1:0] estado,
    output logic [3:0] pares
);

    localparam int unsigned DW = 8;
    localparam int unsigned CW = 3;
    localparam int unsigned SW = 2;
    localparam int unsigned PW = 4;

    typedef enum logic [SW-1:0] {
        ESPERA_A = 2'b00,
        ESPERA_B = 2'b01,
        LISTO    = 2'b10
    } state_t;

    state_t state;
    logic   cargar_src;
    logic   cargar_prev;
    logic   carga_edge;

`ifdef OPERAND_LOADER_SYNC_EN
    // Synchronizer resets high so a strobe held through reset cannot look like a fresh edge
    logic [1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], cargar};
        end
    end

    assign cargar_src = sync_q[1];
`else
    assign cargar_src = cargar;
`endif

    assign carga_edge = cargar_src & ~cargar_prev;
    assign estado     = SW'(state);

    // Load sequencing; cancelar dominates, tomar beats a coincident edge in LISTO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ESPERA_A;
            cargar_prev <= 1'b1;
            A           <= '0;
            B           <= '0;
            Cantidad    <= '0;
            valido      <= 1'b0;
            pares       <= '0;
        end else begin
            cargar_prev <= cargar_src;
            if (cancelar) begin
                state  <= ESPERA_A;
                valido <= 1'b0;
            end else begin
                case (state)
                    ESPERA_A: begin
                        if (carga_edge) begin
                            A     <= DW'(dato_in);
                            state <= ESPERA_B;
                        end
                        valido <= 1'b0;
                    end
                    ESPERA_B: begin
                        if (carga_edge) begin
                            B        <= DW'(dato_in);
                            Cantidad <= CW'(cantidad_in);
                            state    <= LISTO;
                            valido   <= 1'b1;
                        end else begin
                            valido <= 1'b0;
                        end
                    end
                    LISTO: begin
                        if (tomar) begin
                            state  <= ESPERA_A;
                            valido <= 1'b0;
                            pares  <= pares + PW'(1);
                        end else begin
                            valido <= 1'b1;
                        end
                    end
                    default: begin
                        state  <= ESPERA_A;
                        valido <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_operand_loader.sv
// Randomized scoreboard bench for operand_loader; a monitor checks each completed pair on valido rise.
module tb_operand_loader;

`ifdef OPERAND_LOADER_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] dato_in;
    logic       cargar;
    logic [2:0] cantidad_in;
    logic       tomar;
    logic       cancelar;
    logic [7:0] A, B;
    logic [2:0] Cantidad;
    logic       valido;
    logic [1:0] estado;
    logic [3:0] pares;

    operand_loader dut (
        .clk(clk), .rst_n(rst_n), .dato_in(dato_in), .cargar(cargar),
        .cantidad_in(cantidad_in), .tomar(tomar), .cancelar(cancelar),
        .A(A), .B(B), .Cantidad(Cantidad), .valido(valido),
        .estado(estado), .pares(pares)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [18:0] exp_q[$];
    logic [3:0]  pares_exp;
    logic        valido_d = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: every new pair presented is compared with the oldest expected pair
    always @(negedge clk) begin
        if (rst_n && valido && !valido_d) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL monitor_unexpected_pair: got A=%0h B=%0h C=%0h, expected none", A, B, Cantidad);
            end else begin
                chk("monitor_pair", {A, B, Cantidad}, exp_q.pop_front());
            end
        end
        valido_d = valido;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    // One strobe pulse; data held until the (possibly synchronized) load has happened
    task automatic pulse(input logic [7:0] d, input logic [2:0] c);
        @(negedge clk);
        dato_in = d; cantidad_in = c; cargar = 1'b1;
        @(negedge clk);
        cargar = 1'b0;
        repeat (LAT) @(negedge clk);
    endtask

    task automatic cancel_load();
        @(negedge clk);
        cancelar = 1'b1;
        @(negedge clk);
        cancelar = 1'b0;
    endtask

    // Accept the pending pair, optionally with a strobe edge landing on the same clock
    task automatic accept(input logic with_edge, input logic [7:0] d);
        @(negedge clk);
        if (with_edge) begin
            dato_in = d; cargar = 1'b1;
            repeat (LAT) @(negedge clk);
        end
        tomar = 1'b1;
        @(negedge clk);
        tomar = 1'b0; cargar = 1'b0;
        pares_exp = pares_exp + 4'd1;
        repeat (LAT + 1) @(negedge clk);
    endtask

    initial begin
        logic [7:0] a, b, x;
        logic [2:0] c;
        int n;
        dato_in = '0; cantidad_in = '0; tomar = 0; cancelar = 0;
        pares_exp = '0;

        // Reset with strobe held high: nothing loads on release
        cargar = 1'b1; rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_estado", 32'(estado), 32'h0);
        chk("reset_A", 32'(A), 32'h0);
        chk("reset_valido", 32'(valido), 32'h0);
        chk("reset_pares", 32'(pares), 32'h0);
        dato_in = 8'h99;
        rst_n = 1'b1;
        repeat (4 + LAT) @(negedge clk);
        chk("held_reset_estado", 32'(estado), 32'h0);
        chk("held_reset_A", 32'(A), 32'h0);
        cargar = 1'b0;
        repeat (LAT + 1) @(negedge clk);

        // Basic load with latency measurement on the B load
        pulse(8'h5A, 3'd0);
        chk("basic_A", 32'(A), 32'h5A);
        chk("basic_estado_b", 32'(estado), 32'h1);
        exp_q.push_back({8'h5A, 8'hC3, 3'd3});
        @(negedge clk);
        dato_in = 8'hC3; cantidad_in = 3'd3; cargar = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            cargar = 1'b0;
            n++;
        end while (!valido && n < 10);
        chk("basic_latency", 32'(n), 32'(LAT + 1));
        chk("basic_B", 32'(B), 32'hC3);
        chk("basic_cantidad", 32'(Cantidad), 32'h3);
        chk("basic_estado_listo", 32'(estado), 32'h2);

        // tomar and edge together: tomar wins, edge dropped
        accept(1'b1, 8'hFF);
        chk("simul_estado", 32'(estado), 32'h0);
        chk("simul_pares", 32'(pares), 32'(pares_exp));
        chk("simul_A", 32'(A), 32'h5A);
        chk("simul_valido", 32'(valido), 32'h0);

        // Abort a partial load
        pulse(8'h22, 3'd0);
        cancel_load();
        chk("abort_estado", 32'(estado), 32'h0);
        chk("abort_A", 32'(A), 32'h22);
        chk("abort_valido", 32'(valido), 32'h0);
        chk("abort_pares", 32'(pares), 32'(pares_exp));

        // Long strobe loads only A
        @(negedge clk);
        dato_in = 8'h11; cargar = 1'b1;
        repeat (10) @(negedge clk);
        cargar = 1'b0;
        repeat (LAT + 1) @(negedge clk);
        chk("held_estado", 32'(estado), 32'h1);
        chk("held_A", 32'(A), 32'h11);
        chk("held_B", 32'(B), 32'hC3);
        cancel_load();

        // Asynchronous reset mid-load clears everything at once
        pulse(8'h77, 3'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("midreset_A", 32'(A), 32'h0);
        chk("midreset_B", 32'(B), 32'h0);
        chk("midreset_cantidad", 32'(Cantidad), 32'h0);
        chk("midreset_estado", 32'(estado), 32'h0);
        chk("midreset_valido", 32'(valido), 32'h0);
        chk("midreset_pares", 32'(pares), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        pares_exp = '0;
        repeat (2) @(negedge clk);

        // Randomized pairs; more than 16 accepts exercises the pares wrap
        for (int i = 0; i < 40; i++) begin
            a = 8'($urandom); b = 8'($urandom); c = 3'($urandom); x = 8'($urandom);
            pulse(a, 3'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                cancel_load();
                chk("rand_cancel_estado", 32'(estado), 32'h0);
                a = 8'($urandom);
                pulse(a, 3'($urandom));
            end
            exp_q.push_back({a, b, c});
            pulse(b, c);
            chk("rand_valido", 32'(valido), 32'h1);
            chk("rand_estado", 32'(estado), 32'h2);
            if ($urandom_range(0, 2) == 0) begin
                pulse(x, 3'($urandom));
                chk("rand_ignored_edge", 32'({A, B, Cantidad}), 32'({a, b, c}));
            end
            accept(1'($urandom), x);
            chk("rand_accept_estado", 32'(estado), 32'h0);
            chk("rand_pares", 32'(pares), 32'(pares_exp));
            chk("rand_retained", 32'({A, B, Cantidad}), 32'({a, b, c}));
        end

        chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
